mips_multicycle_control: RTL
============================

# mips_multicycle_control

Multicycle main control unit for the MIPS datapath. A Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back cycles and drives every datapath enable and mux select. It sits directly upstream of the ALU control unit: its `alu_op` output is that unit's 2-bit ALUop input, and the instruction's funct field goes to the ALU control unit without passing through this block.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: instruction register bits [31:26]; valid from the DECODE cycle onward.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `ir_write`, `reg_write`, `reg_dst`, `alu_src_a` output 1 each: datapath controls.
- `pc_source` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_src_b` output 2: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- `alu_op` output 2: 00 add, 01 subtract, 10 decode funct.
- `state` output 4: current state, for debug.
- `instr_done` output 1: one-cycle pulse in the final state of each legal instruction.
- `illegal_op` output 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `retired` output `CNT_W`: count of completed legal instructions.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEM_ADDR for lw/sw, EXECUTE for R-type, BRANCH for beq, JUMP for j, ADDI_EXEC for addi, FETCH for any other opcode.
  - MEM_ADDR→MEM_READ for lw, MEM_WRITE for sw. The opcode is re-read here and is held stable by the datapath.
  - MEM_READ→MEM_WB; EXECUTE→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB all →FETCH.
- Outputs are a pure function of the state. Every output not listed below is 0.
  - FETCH: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01, alu_op=00, pc_source=00.
  - DECODE: alu_src_b=11, alu_op=00.
  - MEM_ADDR and ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- `instr_done` is 1 in MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB.
- `retired` increments by 1 at each edge where `instr_done`=1. It wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Cycles per instruction, counted from FETCH: lw 5; sw, R-type and addi 4; beq and j 3; illegal opcode 2 (FETCH, DECODE, then back to FETCH).
- Reset:
  - While `rst`=1, every control output, `instr_done` and `illegal_op` are forced to 0, so no write can occur during reset.
  - At the edge where `rst`=1, `state` becomes FETCH and `retired` becomes 0.
  - FETCH outputs appear in the first cycle with `rst`=0.
- Reset asserted mid-instruction aborts the instruction. `retired` is not incremented on that edge, even if the state was a final state.
- There are no stalls and no handshakes: the memory completes in one cycle.
- `opcode` changes inside DECODE do not matter: the next-state choice is taken from the value present at the DECODE→next edge.

## Structure
- A shared package `mips_ctrl_pkg` holds:
  - the state enumeration and its 4-bit encodings;
  - the opcode constants;
  - the `alu_op` constants ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10, also used by the ALU control unit;
  - the `pc_source` and `alu_src_b` select constants.
- One natural sub-module, `mips_ctrl_decode`: a combinational state→output decoder. The state register, next-state logic and counter stay in the top module.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with opcode=100011. All controls stay 0 and `retired`=0. The first cycle after release shows state=0 with pc_write=1, ir_write=1, mem_read=1.
- lw: opcode=100011. State sequence 0,1,2,3,4,0. mem_to_reg=1 and reg_write=1 only in state 4. `retired` goes 0→1.
- sw then R-type then addi, back to back:
  - sw: sequence 0,1,2,5. mem_write=1 only in state 5.
  - R-type: sequence 0,1,6,7. alu_op=10 in state 6; reg_dst=1 in state 7.
  - addi: sequence 0,1,10,11. reg_dst=0 in state 11.
  - `retired`=3 at the end.
- beq then j: beq gives pc_write_cond=1, alu_op=01, pc_source=01 in state 8. j gives pc_write=1, pc_source=10 in state 9. Each takes 3 cycles.
- Illegal opcode 111111: `illegal_op` pulses in DECODE, the next state is FETCH, there are no writes, and `retired` is unchanged.
- Abort and wrap:
  - `rst` asserted while in state 3 gives FETCH and `retired`=0 on the next edge.
  - With CNT_W=4, 16 completed instructions wrap `retired` from 15 to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared types and constants for the MIPS multicycle control
//               unit and the downstream ALU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Control FSM states with fixed 4-bit encodings (visible on the debug port)
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUop encodings shared with the ALU control unit
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B mux selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Full set of per-state datapath controls
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_decode
// Description : Combinational Moore decoder, FSM state to datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Every control defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule : mips_ctrl_decode
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Multicycle MIPS main control FSM with retired-instruction
//               counter. Outputs are held at 0 while reset is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    ctrl_t            w_dec;
    ctrl_t            w_ctrl;
    logic             w_op_legal;
    logic [CNT_W-1:0] r_retired;

    mips_ctrl_decode u_decode (
        .state (r_state),
        .ctrl  (w_dec)
    );

    // Reset masks every control so no write can slip through while held
    assign w_ctrl = rst ? '0 : w_dec;

    assign w_op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW)  ||
                        (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                        (opcode == OP_J)     || (opcode == OP_ADDI);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; opcode is consulted in DECODE and again in MEM_ADDR
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = S_MEM_WB;
            S_EXECUTE:   w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    // Retired counter; the reset branch wins so an aborted final state is not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_ctrl.instr_done) begin
            r_retired <= r_retired + C_CNT_ONE;
        end
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_write     = w_ctrl.reg_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign pc_source     = w_ctrl.pc_source;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign instr_done    = w_ctrl.instr_done;
    assign illegal_op    = !rst && (r_state == S_DECODE) && !w_op_legal;
    assign state         = r_state;
    assign retired       = r_retired;

endmodule : mips_multicycle_control
`default_nettype wire
